neg_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit `two_s_complement` negation datapath among `N_REQ` requesters. Each requester offers a 4-bit operand over a valid/ready handshake. The block grants one requester per cycle, drives the shared datapath, and registers the negated result with the winner's ID into a single-entry output stage with its own valid/ready handshake. It sits between requesting lab blocks (counters, ALU front-ends) and any consumer of negated values.

---
 rtl/neg_arb_pkg.sv | 12 +
 rtl/two_s_complement.sv | 11 +
 rtl/neg_arbiter.sv | 101 ++++++++++
 tb/tb_neg_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/neg_arb_pkg.sv
// Shared constants and FSM state type for the negation arbiter.
package neg_arb_pkg;

  localparam int DATA_W = 4;
  localparam logic [DATA_W-1:0] NEG_MIN = 4'b1000;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/two_s_complement.sv
// 4-bit two's complement negation; -8 wraps back to itself.
module two_s_complement
  import neg_arb_pkg::*;
(
  input  logic [DATA_W-1:0] In,
  output logic [DATA_W-1:0] Out
);

  assign Out = ~In + DATA_W'(1);

endmodule

// File: rtl/neg_arbiter.sv
// Round-robin arbiter sharing one negation datapath among N_REQ requesters.
// Define NEG_ARB_OVF_EN to add the registered out_ovf flag for operand 4'b1000.
module neg_arbiter
  import neg_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
`ifdef NEG_ARB_OVF_EN
  output logic                    out_ovf,
`endif
  input  logic                    out_ready
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               ovf_q, ovf_d;

  logic               can_accept;
  logic               grant_any;
  logic [ID_W-1:0]    winner;
  logic [DATA_W-1:0]  operand;
  logic [DATA_W-1:0]  negated;
  int unsigned        idx;

  assign can_accept = (state_q == ST_EMPTY) | out_ready;
  assign grant_any  = !rst && can_accept && (|req_valid);

  // Scan from the highest offset down so the nearest valid index after ptr wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (req_valid[idx]) winner = ID_W'(idx);
    end
  end

  assign req_ready = grant_any ? (N_REQ'(1) << winner) : '0;
  assign operand   = req_data[winner*DATA_W +: DATA_W];

  two_s_complement u_neg (
    .In  (operand),
    .Out (negated)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    ovf_d   = ovf_q;
    if (grant_any) begin
      state_d = ST_FULL;
      data_d  = negated;
      id_d    = winner;
      ovf_d   = (operand == NEG_MIN);
      ptr_d   = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;

`ifdef NEG_ARB_OVF_EN
  assign out_ovf = ovf_q;
`else
  logic unusedOvf;
  assign unusedOvf = ovf_q;
`endif

endmodule

// File: tb/tb_neg_arbiter.sv
// Self-checking bench for neg_arbiter: per-cycle reference model plus directed checks.
// Build with NEG_ARB_OVF_EN defined to also check out_ovf.
module tb_neg_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic              clk;
  logic              rst;
  logic [N_REQ-1:0]  req_valid;
  logic [4*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]  req_ready;
  logic              out_valid;
  logic [3:0]        out_data;
  logic [ID_W-1:0]   out_id;
  logic              out_ready;
`ifdef NEG_ARB_OVF_EN
  logic              out_ovf;
`endif

  int checks   = 0;
  int failures = 0;
  bit running  = 1'b0;

  // Reference model state, describing the DUT after the most recent edge.
  int mFull = 0;
  int mPtr  = 0;
  int mData = 0;
  int mId   = 0;
  int mOvf  = 0;
  int mWin;
  int mOp;
  int expRrModel;

  neg_arbiter #(.N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
`ifdef NEG_ARB_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [15:0] d, input logic rdy);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_data  = d;
    out_ready = rdy;
  endtask

  // Model: grant = first valid index at or after ptr when there is room; result = (16 - op) mod 16.
  always @(negedge clk) begin
    if (running) begin
      mWin = -1;
      if (!rst && (mFull == 0 || out_ready)) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (mWin < 0 && req_valid[(mPtr + k) % N_REQ]) mWin = (mPtr + k) % N_REQ;
        end
      end
      expRrModel = (mWin >= 0) ? (1 << mWin) : 0;
      checkOutput("model_req_ready", int'(req_ready), expRrModel);
      checkOutput("model_out_valid", int'(out_valid), mFull);
      if (mFull != 0) begin
        checkOutput("model_out_data", int'(out_data), mData);
        checkOutput("model_out_id", int'(out_id), mId);
`ifdef NEG_ARB_OVF_EN
        checkOutput("model_out_ovf", int'(out_ovf), mOvf);
`endif
      end
      if (rst) begin
        mFull = 0; mPtr = 0; mData = 0; mId = 0; mOvf = 0;
      end else if (mWin >= 0) begin
        mOp   = int'(req_data >> (4 * mWin)) & 15;
        mData = (16 - mOp) % 16;
        mId   = mWin;
        mOvf  = (mOp == 8) ? 1 : 0;
        mPtr  = (mWin + 1) % N_REQ;
        mFull = 1;
      end else if (out_ready) begin
        mFull = 0;
      end
    end
  end

  logic [3:0] rrReady [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rrData  [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1100, 4'b1111};
  logic [1:0] rrId    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] bndOp   [3] = '{4'b0000, 4'b1000, 4'b1111};
  logic [3:0] bndRes  [3] = '{4'b0000, 4'b1000, 4'b0001};

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 16'hFFFF;
    out_ready = 1'b0;
    running   = 1'b1;

    // Reset held two cycles with every requester valid.
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", int'(req_ready), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_id", int'(out_id), 0);
`ifdef NEG_ARB_OVF_EN
    checkOutput("rst_out_ovf", int'(out_ovf), 0);
`endif

    // Single request from requester 0.
    applyStimulus(1'b0, 4'b0001, 16'h0003, 1'b1);
    @(negedge clk);
    checkOutput("single_req_ready", int'(req_ready), 1);
    applyStimulus(1'b0, 4'b0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("single_out_valid", int'(out_valid), 1);
    checkOutput("single_out_data", int'(out_data), 4'hD);
    checkOutput("single_out_id", int'(out_id), 0);

    // Round-robin from ptr = 0 with all four valid.
    applyStimulus(1'b1, 4'b0000, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111, 16'h4321, 1'b1);
      @(negedge clk);
      checkOutput("rr_req_ready", int'(req_ready), int'(rrReady[i]));
      if (i > 0) begin
        checkOutput("rr_out_data", int'(out_data), int'(rrData[i-1]));
        checkOutput("rr_out_id", int'(out_id), int'(rrId[i-1]));
      end
    end
    applyStimulus(1'b0, 4'b0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("rr_last_data", int'(out_data), int'(rrData[4]));
    checkOutput("rr_last_id", int'(out_id), int'(rrId[4]));

    // Backpressure on requester 2 with operand 5.
    applyStimulus(1'b0, 4'b0100, 16'h0500, 1'b1);
    @(negedge clk);
    checkOutput("bp_first_grant", int'(req_ready), 4'b0100);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0100, 16'h0500, 1'b0);
      @(negedge clk);
      checkOutput("bp_req_ready", int'(req_ready), 0);
      checkOutput("bp_out_valid", int'(out_valid), 1);
      checkOutput("bp_out_data", int'(out_data), 4'hB);
      checkOutput("bp_out_id", int'(out_id), 2);
    end
    applyStimulus(1'b0, 4'b0100, 16'h0500, 1'b1);
    @(negedge clk);
    checkOutput("bp_drain_grant", int'(req_ready), 4'b0100);
    applyStimulus(1'b0, 4'b0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("bp_valid_kept", int'(out_valid), 1);
    checkOutput("bp_reload_data", int'(out_data), 4'hB);

    // Boundary operands through requester 0.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0001, {12'h000, bndOp[i]}, 1'b1);
      applyStimulus(1'b0, 4'b0000, 16'h0000, 1'b1);
      @(negedge clk);
      checkOutput("bnd_out_data", int'(out_data), int'(bndRes[i]));
`ifdef NEG_ARB_OVF_EN
      checkOutput("bnd_out_ovf", int'(out_ovf), (bndOp[i] == 4'b1000) ? 1 : 0);
`endif
    end

    // Reset while FULL with out_id = 2, then ptr restarts at 0.
    applyStimulus(1'b0, 4'b0100, 16'h0700, 1'b1);
    @(negedge clk);
    checkOutput("mid_grant2", int'(req_ready), 4'b0100);
    applyStimulus(1'b1, 4'b0000, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("mid_full_id", int'(out_id), 2);
    checkOutput("mid_full_valid", int'(out_valid), 1);
    checkOutput("mid_rst_ready", int'(req_ready), 0);
    applyStimulus(1'b0, 4'b1010, 16'h5030, 1'b1);
    @(negedge clk);
    checkOutput("mid_discard", int'(out_valid), 0);
    checkOutput("mid_ptr_zero", int'(req_ready), 4'b0010);
    applyStimulus(1'b0, 4'b0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("mid_out_id", int'(out_id), 1);
    checkOutput("mid_out_data", int'(out_data), 4'hD);

    applyStimulus(1'b0, 4'b0000, 16'h0000, 1'b1);
    @(negedge clk);
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
